// File: rtl/stack_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_seq_pkg
//  Description : Shared opcodes, SP strobe patterns and sequencer state
//                encoding for the stack sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_seq_pkg;

    // Opcodes presented by the control unit (110/111 behave as NOP)
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_DROP  = 3'b011;
    localparam logic [2:0] OP_PEEK  = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    // Stack pointer control, ordered [select, inc, dec]
    localparam logic [2:0] SP_NONE = 3'b000;
    localparam logic [2:0] SP_SEL  = 3'b100;
    localparam logic [2:0] SP_INC  = 3'b010;
    localparam logic [2:0] SP_DEC  = 3'b001;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PUSH_INC = 4'd1,
        S_PUSH_WR  = 4'd2,
        S_POP_RD   = 4'd3,
        S_POP_DEC  = 4'd4,
        S_DROP_DEC = 4'd5,
        S_PEEK_RD  = 4'd6,
        S_CLR      = 4'd7,
        S_FIN_NOP  = 4'd8,
        S_FIN_ERR  = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stack_sequencer_if
//  Description : Op request handshake plus the stack/SP/R/T strobe bundle
//                driven by the stack sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stack_sequencer_if #(
    parameter int DEPTH_W = 9
);
    logic               i_op_valid;
    logic [2:0]         i_op;
    logic               o_op_ready;
    logic               o_done;
    logic               o_err;
    logic               o_stkWCtrl;
    logic               o_stkSCtrl;
    logic [2:0]         o_spCtrl;
    logic               o_RSCtrl;
    logic               o_TWCtrl;
    logic               o_TIn;
    logic               o_baseS;
    logic [15:0]        o_base;
    logic [DEPTH_W-1:0] o_depth;
    logic               o_overflow;
    logic               o_underflow;

    // Requester side (control unit)
    modport master (
        output i_op_valid, i_op,
        input  o_op_ready, o_done, o_err, o_stkWCtrl, o_stkSCtrl, o_spCtrl,
               o_RSCtrl, o_TWCtrl, o_TIn, o_baseS, o_base, o_depth,
               o_overflow, o_underflow
    );

    // Sequencer side
    modport slave (
        input  i_op_valid, i_op,
        output o_op_ready, o_done, o_err, o_stkWCtrl, o_stkSCtrl, o_spCtrl,
               o_RSCtrl, o_TWCtrl, o_TIn, o_baseS, o_base, o_depth,
               o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/stack_sequencer_depth_counter.sv
`default_nettype none
// ============================================================================
//  Module      : depth_counter
//  Description : Saturating up/down entry counter with clear; increments are
//                blocked when full and decrements when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module depth_counter #(
    parameter int DEPTH   = 256,
    parameter int DEPTH_W = 9
) (
    input  wire logic               i_clock,
    input  wire logic               i_reset_n,
    input  wire logic               i_clr,
    input  wire logic               i_inc,
    input  wire logic               i_dec,
    output logic [DEPTH_W-1:0]      o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam logic [DEPTH_W-1:0] c_FULL_COUNT = DEPTH_W'(DEPTH);

    logic [DEPTH_W-1:0] r_count;

    // Entry count: clear wins, then gated increment/decrement
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL_COUNT);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_sequencer
//  Description : Multi-cycle controller sequencing memory stack, SP, R/T
//                hand-off and BUS drive for stack ops; tracks depth and
//                sticky overflow/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int          DEPTH      = 256,
    parameter int          DEPTH_W    = 9,
    parameter logic [15:0] STACK_BASE = 16'h0000
) (
    input  wire logic        i_clock,
    input  wire logic        i_reset_n,
    stack_sequencer_if.slave bus
);
    state_t             r_state;
    state_t             w_nextState;
    logic               r_errIsOvf;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_full;
    logic               w_empty;
    logic [DEPTH_W-1:0] w_depth;
    logic               w_accept;

    assign w_accept = bus.i_op_valid && (r_state == S_IDLE);

    // Entry count; only the update phases touch it
    depth_counter #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clr     (r_state == S_CLR),
        .i_inc     (r_state == S_PUSH_WR),
        .i_dec     ((r_state == S_POP_DEC) || (r_state == S_DROP_DEC)),
        .o_count   (w_depth),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Remember which flag a rejected op must set once it reaches FIN_ERR
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_errIsOvf <= 1'b0;
        end else if (w_accept) begin
            r_errIsOvf <= (bus.i_op == OP_PUSH);
        end
    end

    // Sticky error flags: set by a rejected op, cleared only by CLEAR
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (r_state == S_CLR) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (r_state == S_FIN_ERR) begin
            if (r_errIsOvf) begin
                r_overflow <= 1'b1;
            end else begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Next-state selection and state-decoded strobes
    always_comb begin
        w_nextState     = r_state;
        bus.o_op_ready  = 1'b0;
        bus.o_done      = 1'b0;
        bus.o_err       = 1'b0;
        bus.o_stkWCtrl  = 1'b0;
        bus.o_stkSCtrl  = 1'b0;
        bus.o_spCtrl    = SP_NONE;
        bus.o_RSCtrl    = 1'b0;
        bus.o_TWCtrl    = 1'b0;
        bus.o_TIn       = 1'b0;
        bus.o_baseS     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.o_op_ready = 1'b1;
                if (bus.i_op_valid) begin
                    case (bus.i_op)
                        OP_PUSH:  w_nextState = w_full  ? S_FIN_ERR : S_PUSH_INC;
                        OP_POP:   w_nextState = w_empty ? S_FIN_ERR : S_POP_RD;
                        OP_DROP:  w_nextState = w_empty ? S_FIN_ERR : S_DROP_DEC;
                        OP_PEEK:  w_nextState = w_empty ? S_FIN_ERR : S_PEEK_RD;
                        OP_CLEAR: w_nextState = S_CLR;
                        default:  w_nextState = S_FIN_NOP;
                    endcase
                end
            end
            S_PUSH_INC: begin
                bus.o_spCtrl = SP_INC;
                w_nextState  = S_PUSH_WR;
            end
            S_PUSH_WR: begin
                bus.o_RSCtrl   = 1'b1;
                bus.o_stkWCtrl = 1'b1;
                bus.o_done     = 1'b1;
                w_nextState    = S_IDLE;
            end
            S_POP_RD: begin
                bus.o_stkSCtrl = 1'b1;
                bus.o_TIn      = 1'b1;
                bus.o_TWCtrl   = 1'b1;
                w_nextState    = S_POP_DEC;
            end
            S_POP_DEC, S_DROP_DEC: begin
                bus.o_spCtrl = SP_DEC;
                bus.o_done   = 1'b1;
                w_nextState  = S_IDLE;
            end
            S_PEEK_RD: begin
                bus.o_stkSCtrl = 1'b1;
                bus.o_TIn      = 1'b1;
                bus.o_TWCtrl   = 1'b1;
                bus.o_done     = 1'b1;
                w_nextState    = S_IDLE;
            end
            S_CLR: begin
                bus.o_baseS  = 1'b1;
                bus.o_spCtrl = SP_SEL;
                bus.o_done   = 1'b1;
                w_nextState  = S_IDLE;
            end
            S_FIN_NOP: begin
                bus.o_done  = 1'b1;
                w_nextState = S_IDLE;
            end
            S_FIN_ERR: begin
                bus.o_done  = 1'b1;
                bus.o_err   = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign bus.o_base      = STACK_BASE;
    assign bus.o_depth     = w_depth;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_sequencer
//  Description : Scoreboard bench for stack_sequencer (DEPTH=4 build) with a
//                queue-of-phases reference model and randomised op stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;
    localparam int          DEPTH   = 4;
    localparam int          DEPTH_W = 3;
    localparam logic [15:0] BASE    = 16'hA5C3;

    typedef struct packed {
        logic        stkW;
        logic        stkS;
        logic [2:0]  sp;
        logic        rs;
        logic        tw;
        logic        tin;
        logic        bs;
        logic        done;
        logic        err;
        logic        rdy;
        logic [2:0]  depth;
        logic        ovf;
        logic        unf;
        logic [15:0] base;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } ent_t;

    logic clk;
    logic rst_n;
    ent_t expQ[$];
    int   errors  = 0;
    int   checks  = 0;
    int   accepts = 0;
    int   dones   = 0;
    int   mDepth  = 0;
    bit   mOvf    = 1'b0;
    bit   mUnf    = 1'b0;
    bit   monEn   = 1'b0;

    stack_sequencer_if #(.DEPTH_W(DEPTH_W)) sif();

    stack_sequencer #(
        .DEPTH      (DEPTH),
        .DEPTH_W    (DEPTH_W),
        .STACK_BASE (BASE)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(int d, bit ov, bit un, bit rdy);
        obs_t o;
        o       = '0;
        o.depth = 3'(d);
        o.ovf   = ov;
        o.unf   = un;
        o.rdy   = rdy;
        o.base  = BASE;
        return o;
    endfunction

    function automatic obs_t act();
        obs_t o;
        o.stkW  = sif.o_stkWCtrl;
        o.stkS  = sif.o_stkSCtrl;
        o.sp    = sif.o_spCtrl;
        o.rs    = sif.o_RSCtrl;
        o.tw    = sif.o_TWCtrl;
        o.tin   = sif.o_TIn;
        o.bs    = sif.o_baseS;
        o.done  = sif.o_done;
        o.err   = sif.o_err;
        o.rdy   = sif.o_op_ready;
        o.depth = sif.o_depth;
        o.ovf   = sif.o_overflow;
        o.unf   = sif.o_underflow;
        o.base  = sif.o_base;
        return o;
    endfunction

    task automatic check(input string name, input obs_t want, input obs_t got);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
        end
    endtask

    function automatic void pushE(input string n, input obs_t v);
        ent_t e;
        e.name = n;
        e.v    = v;
        expQ.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents either the next expected phase
    // of an accepted op or the idle picture of the reference model
    always @(negedge clk) begin
        if (monEn) begin
            obs_t a;
            ent_t e;
            a = act();
            if (a.done) dones++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check(e.name, e.v, a);
            end else begin
                check("idle", mk(mDepth, mOvf, mUnf, 1'b1), a);
            end
            checks++;
            if ($countones({a.rs, a.stkS, a.bs}) > 1 || !$onehot0(a.sp)) begin
                errors++;
                $display("FAIL invariant at %0t: drivers=%b sp=%b", $time,
                         {a.rs, a.stkS, a.bs}, a.sp);
            end
        end
    end

    // Issue one op and queue the phase sequence the spec prescribes for it
    task automatic issue(input logic [2:0] op);
        int   guard;
        obs_t b;
        obs_t v;
        guard = 0;
        @(negedge clk);
        while (!sif.o_op_ready) begin
            guard++;
            if (guard > 16) begin
                checks++;
                errors++;
                $display("FAIL readyTimeout got=0 want=1");
                return;
            end
            @(negedge clk);
        end
        sif.i_op_valid = 1'b1;
        sif.i_op       = op;
        @(posedge clk);
        #1;
        sif.i_op_valid = 1'b0;
        sif.i_op       = 3'($urandom);
        accepts++;
        b = mk(mDepth, mOvf, mUnf, 1'b0);
        v = b;
        case (op)
            3'b001: begin
                if (mDepth == DEPTH) begin
                    v.done = 1'b1; v.err = 1'b1; pushE("pushErr", v); mOvf = 1'b1;
                end else begin
                    v.sp = 3'b010; pushE("pushInc", v);
                    v = b; v.rs = 1'b1; v.stkW = 1'b1; v.done = 1'b1; pushE("pushWr", v);
                    mDepth = mDepth + 1;
                end
            end
            3'b010: begin
                if (mDepth == 0) begin
                    v.done = 1'b1; v.err = 1'b1; pushE("popErr", v); mUnf = 1'b1;
                end else begin
                    v.stkS = 1'b1; v.tin = 1'b1; v.tw = 1'b1; pushE("popRd", v);
                    v = b; v.sp = 3'b001; v.done = 1'b1; pushE("popDec", v);
                    mDepth = mDepth - 1;
                end
            end
            3'b011: begin
                if (mDepth == 0) begin
                    v.done = 1'b1; v.err = 1'b1; pushE("dropErr", v); mUnf = 1'b1;
                end else begin
                    v.sp = 3'b001; v.done = 1'b1; pushE("dropDec", v);
                    mDepth = mDepth - 1;
                end
            end
            3'b100: begin
                if (mDepth == 0) begin
                    v.done = 1'b1; v.err = 1'b1; pushE("peekErr", v); mUnf = 1'b1;
                end else begin
                    v.stkS = 1'b1; v.tin = 1'b1; v.tw = 1'b1; v.done = 1'b1;
                    pushE("peekRd", v);
                end
            end
            3'b101: begin
                v.bs = 1'b1; v.sp = 3'b100; v.done = 1'b1; pushE("clear", v);
                mDepth = 0; mOvf = 1'b0; mUnf = 1'b0;
            end
            default: begin
                v.done = 1'b1; pushE("nop", v);
            end
        endcase
    endtask

    initial begin
        int guard;
        rst_n          = 1'b0;
        sif.i_op_valid = 1'b0;
        sif.i_op       = 3'b000;
        repeat (3) @(negedge clk);
        check("resetState", mk(0, 1'b0, 1'b0, 1'b1), act());
        rst_n = 1'b1;
        monEn = 1'b1;

        // Directed: fill past the top, then pop and refill while overflow sticks
        issue(3'b101);
        repeat (5) issue(3'b001);
        issue(3'b010);
        issue(3'b001);
        issue(3'b010);

        // Reset while PUSH_INC is live: strobes must drop without waiting for a clock
        issue(3'b001);
        check("preAbort", expQ[0].v, act());
        monEn = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("abort", mk(0, 1'b0, 1'b0, 1'b1), act());
        expQ.delete();
        accepts--;
        mDepth = 0; mOvf = 1'b0; mUnf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        monEn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: underflow on each reading op, then reserved opcodes
        issue(3'b101);
        issue(3'b010);
        issue(3'b011);
        issue(3'b100);
        issue(3'b111);
        issue(3'b110);
        issue(3'b000);
        issue(3'b101);

        // Randomised op stream, biased towards PUSH so both limits are hit
        for (int i = 0; i < 1000; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 7)       issue(3'b001);
            else if (r < 11) issue(3'b010);
            else if (r < 13) issue(3'b011);
            else if (r < 15) issue(3'b100);
            else if (r < 16) issue(3'b101);
            else             issue(3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0 || accepts != dones) begin
            errors++;
            $display("FAIL doneCount: dones=%0d accepts=%0d pending=%0d",
                     dones, accepts, expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Multi-cycle controller that sequences the memory stack, stack pointer, R/T bus hand-off and shared BUS drive for stack operations requested by the control unit. It accepts one operation per valid/ready handshake and steps through fixed per-op phases. It tracks stack depth and reports overflow/underflow. It sits between controlunit and the memorystack/stackpointer/registerR/registerT strobes, and is the only source of those strobes for stack ops.

Parameters:
DEPTH, 256, number of stack entries; legal depth range 0..DEPTH
DEPTH_W, 9, width of depth counter; must satisfy 2**DEPTH_W > DEPTH
STACK_BASE, 16'h0000, value driven onto BUS to reload SP on CLEAR

Ports:
i_clock  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_op_valid  in  1  op request valid
i_op  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 DROP, 100 PEEK, 101 CLEAR, 110/111 treated as NOP
o_op_ready  out  1  high only in IDLE
o_done  out  1  one-cycle pulse in final cycle of every accepted op
o_err  out  1  qualifies o_done: op was rejected (overflow/underflow)
o_stkWCtrl  out  1  memorystack write
o_stkSCtrl  out  1  memorystack drives BUS
o_spCtrl  out  3  [select, inc, dec]; at most one bit set
o_RSCtrl  out  1  registerR drives BUS
o_TWCtrl  out  1  registerT write
o_TIn  out  1  T input mux select: 1 = BUS
o_baseS  out  1  sequencer drives o_base onto BUS
o_base  out  16  constant STACK_BASE
o_depth  out  DEPTH_W  current entry count
o_overflow  out  1  sticky: PUSH attempted at depth==DEPTH
o_underflow  out  1  sticky: POP/DROP/PEEK attempted at depth==0

Behaviour:
- Reset (async assert, sync deassert by upstream): state IDLE; all strobes 0; o_done=o_err=0; o_depth=0; sticky flags 0; o_op_ready=1. Assertion mid-op aborts immediately. SP is not reset here, so the CU issues CLEAR after reset.
- States: IDLE, PUSH_INC, PUSH_WR, POP_RD, POP_DEC, DROP_DEC, PEEK_RD, CLR, FIN_NOP, FIN_ERR.
- Handshake: accept on rising edge with i_op_valid & o_op_ready. i_op is sampled only then. There is no queue, and valid while not ready is ignored (held by requester).
- Transitions from IDLE on accept:
  - PUSH: depth==DEPTH goes to FIN_ERR; else PUSH_INC.
  - POP: depth==0 goes to FIN_ERR; else POP_RD.
  - DROP: depth==0 goes to FIN_ERR; else DROP_DEC.
  - PEEK: depth==0 goes to FIN_ERR; else PEEK_RD.
  - CLEAR goes to CLR. NOP, 110 and 111 go to FIN_NOP.
- PUSH_INC: spCtrl=010. Next PUSH_WR: RSCtrl=1, stkWCtrl=1, done=1, depth+1.
- POP_RD: stkSCtrl=1, TIn=1, TWCtrl=1. Next POP_DEC: spCtrl=001, done=1, depth-1.
- DROP_DEC: spCtrl=001, done=1, depth-1.
- PEEK_RD: stkSCtrl=1, TIn=1, TWCtrl=1, done=1; depth unchanged.
- CLR: baseS=1, spCtrl=100, done=1; depth := 0; both sticky flags cleared.
- FIN_NOP: done=1, no strobes.
- FIN_ERR: done=1, err=1, no strobes; sets the matching sticky flag; depth unchanged.
- Every terminal state returns to IDLE next cycle. Latency from accept to done: PUSH/POP 2 cycles; others 1 cycle. Back-to-back issue rate is one op per latency+1 cycles.
- All outputs are registered/state-decoded, so no combinational path from i_op to strobes.
- Invariants:
  - At most one of RSCtrl, stkSCtrl, baseS is high in any cycle (single BUS driver).
  - o_spCtrl is one-hot or zero.
  - o_depth never exceeds DEPTH and never wraps below 0.
- Sticky flags persist across later successful ops until CLEAR or reset.

Decomposition:
- Package stack_seq_pkg holds: opcode constants, state encoding, and SP_SEL=100 / SP_INC=010 / SP_DEC=001 constants.
- One sub-module, depth_counter: DEPTH_W-bit up/down counter with clear and full/empty outputs. Inc/dec are gated by full/empty.
- The FSM and strobe decode live in stack_sequencer.

Test Plan:
- Reset, CLEAR, PUSH x3 -> CLEAR asserts baseS+spCtrl=100 for 1 cycle. Each PUSH shows spCtrl=010 then RSCtrl+stkWCtrl with done on cycle 2; o_depth=3.
- POP at depth 3 -> cycle 1 stkSCtrl=TWCtrl=TIn=1, cycle 2 spCtrl=001+done; o_depth=2; ready low for 2 cycles, high on 3rd.
- DEPTH=4 build: PUSH x5 -> 5th gives done+err with zero strobes; o_overflow=1; o_depth=4. Then POP succeeds and o_overflow stays 1 until CLEAR.
- After CLEAR, POP, DROP and PEEK each -> done+err, no strobes, o_underflow=1, o_depth=0. Op 111 -> done, err=0, no strobes.
- Assert i_reset_n=0 in PUSH_INC (between cycles) -> strobes drop immediately. After release: IDLE, ready=1, depth=0, no PUSH_WR write.
- Randomised 1000 ops with a reference depth model -> depth matches, the single-BUS-driver invariant never violated, exactly one done per accept.
